// File: rtl/zet_prefetch_pkg.sv
// Shared types and defaults for the Zet instruction prefetch queue.
// Optional feature macro: ZET_PREFETCH_BYPASS_EN (see zet_prefetch.sv).
package zet_prefetch_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDrop = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_DEPTH    = 6;
    localparam logic [19:0] DEFAULT_RST_ADDR = 20'hFFFF0;

    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/zet_prefetch_buf.sv
// Byte-wide circular buffer: 1-or-2-byte write port, 2-byte read port, level count.
// Unfilled read lanes return 8'h00.
module zet_prefetch_buf
    import zet_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic                        wr_two,
    input  logic [15:0]                 wr_data,
    input  logic                        rd_en,
    input  logic                        rd_two,
    output logic [15:0]                 rd_data,
    output logic [lvl_width(DEPTH)-1:0] level
);

    localparam int unsigned LW = lvl_width(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
    logic [LW-1:0] level_q, level_d;
    logic [1:0]    wr_n, rd_n;

    // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + {{(PW-1){1'b0}}, n};
        if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
        return s[PW-1:0];
    endfunction

    always_comb begin
        wr_n    = wr_en ? (wr_two ? 2'd2 : 2'd1) : 2'd0;
        rd_n    = rd_en ? (rd_two ? 2'd2 : 2'd1) : 2'd0;
        head_p1 = ptr_add(head_q, 2'd1);
        tail_p1 = ptr_add(tail_q, 2'd1);
        head_d  = ptr_add(head_q, rd_n);
        tail_d  = ptr_add(tail_q, wr_n);
        level_d = level_q + LW'(wr_n) - LW'(rd_n);
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !clr && wr_en) begin
            mem[tail_q] <= wr_data[7:0];
            if (wr_two) mem[tail_p1] <= wr_data[15:8];
        end
    end

    always_comb begin
        rd_data = 16'h0000;
        if (level_q != '0) rd_data[7:0] = mem[head_q];
        if (level_q >= LW'(2)) rd_data[15:8] = mem[head_p1];
    end

    assign level = level_q;

endmodule

// File: rtl/zet_prefetch.sv
// Zet prefetch queue top: fetch address, bus FSM, flush handling, queue front-end.
// Define ZET_PREFETCH_BYPASS_EN to forward ack data to rd_data when the queue is empty.
module zet_prefetch
    import zet_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter logic [19:0] RST_ADDR = DEFAULT_RST_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [19:0] flush_addr,
    input  logic        rd_en,
    input  logic        rd_two,
    output logic [15:0] rd_data,
    output logic        q_block,
    output logic [3:0]  q_level,
    output logic [18:0] mem_adr,
    output logic        mem_stb,
    input  logic        mem_ack,
    input  logic [15:0] mem_dat
);

    localparam int unsigned LW = lvl_width(DEPTH);

    state_e        state_q, state_d;
    logic [19:0]   fa_q, fa_d;
    logic [LW-1:0] level, free, avail;
    logic [15:0]   buf_rd_data, ack_bytes;
    logic [1:0]    need, arr_n;
    logic          ack_take, space_ok, pop;
    logic          buf_wr_en, buf_wr_two, buf_rd_en;
    logic [15:0]   buf_wr_data;

    // Odd fetch address: only the high lane of the returned word belongs to the stream.
    assign ack_take  = (state_q == StReq) && mem_ack && !flush;
    assign arr_n     = fa_q[0] ? 2'd1 : 2'd2;
    assign ack_bytes = fa_q[0] ? {8'h00, mem_dat[15:8]} : mem_dat;
    assign free      = LW'(DEPTH) - level;
    assign space_ok  = fa_q[0] ? (free >= LW'(1)) : (free >= LW'(2));
    assign need      = rd_two ? 2'd2 : 2'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            fa_q    <= RST_ADDR;
        end else begin
            state_q <= state_d;
            fa_q    <= fa_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (flush || space_ok) state_d = StReq;
            StReq: begin
                if (flush)        state_d = mem_ack ? StIdle : StDrop;
                else if (mem_ack) state_d = StIdle;
            end
            StDrop: if (!flush && mem_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_stb = (state_q == StReq) || (state_q == StDrop);
        mem_adr = fa_q[19:1];
    end

    always_comb begin
        fa_d = fa_q;
        if (flush)         fa_d = flush_addr;
        else if (ack_take) fa_d = fa_q + {18'd0, arr_n};
    end

`ifdef ZET_PREFETCH_BYPASS_EN
    logic byp;
    assign byp     = (level == '0) && ack_take;
    assign avail   = level + (byp ? LW'(arr_n) : '0);
    assign rd_data = byp ? ack_bytes : buf_rd_data;
`else
    assign avail   = level;
    assign rd_data = buf_rd_data;
`endif

    assign q_block = rd_en && (avail < LW'(need));
    assign pop     = rd_en && !q_block && !flush;

    always_comb begin
        buf_wr_en   = ack_take;
        buf_wr_two  = !fa_q[0];
        buf_wr_data = ack_bytes;
        buf_rd_en   = pop;
`ifdef ZET_PREFETCH_BYPASS_EN
        // Bytes taken straight off the bus never enter the queue.
        if (byp && pop) begin
            buf_rd_en = 1'b0;
            if (need >= arr_n) begin
                buf_wr_en = 1'b0;
            end else begin
                buf_wr_two  = 1'b0;
                buf_wr_data = {8'h00, mem_dat[15:8]};
            end
        end
`endif
    end

    zet_prefetch_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .wr_en  (buf_wr_en),
        .wr_two (buf_wr_two),
        .wr_data(buf_wr_data),
        .rd_en  (buf_rd_en),
        .rd_two (rd_two),
        .rd_data(buf_rd_data),
        .level  (level)
    );

    assign q_level = 4'(level);

endmodule
